// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative HI/LO multiply/divide unit for the EX stage with stall request.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] mf_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_hi, r_lo, r_acc_hi, r_acc_lo, r_b, r_rs;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div, r_neg_q, r_neg_r, r_dz;
    logic w_r, w_mult, w_multu, w_div, w_divu, w_mfhi, w_mthi, w_mflo, w_mtlo;
    logic w_md, w_signed, w_start;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_hi_nx, w_lo_nx, w_q, w_rem, w_wb_hi, w_wb_lo;
    logic [WIDTH:0]     w_add, w_rsh, w_diff;
    logic [2*WIDTH-1:0] w_prod;
    assign w_r      = OpCode == 6'h00;
    assign w_mult   = w_r & (Funct == 6'h18);
    assign w_multu  = w_r & (Funct == 6'h19);
    assign w_div    = w_r & (Funct == 6'h1a);
    assign w_divu   = w_r & (Funct == 6'h1b);
    assign w_mfhi   = w_r & (Funct == 6'h10);
    assign w_mthi   = w_r & (Funct == 6'h11);
    assign w_mflo   = w_r & (Funct == 6'h12);
    assign w_mtlo   = w_r & (Funct == 6'h13);
    assign w_md     = w_mult | w_multu | w_div | w_divu;
    assign w_signed = w_mult | w_div;
    assign busy     = r_state == S_RUN;
    assign stall    = ex_valid & (w_md | w_mfhi | w_mthi | w_mflo | w_mtlo) & busy;
    assign w_start  = ex_valid & w_md & !busy;
    assign w_a_mag  = (w_signed & rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign w_b_mag  = (w_signed & rt_data[WIDTH-1]) ? -rt_data : rt_data;
    // Multiply: shift-add with multiplier in acc_lo; divide: restoring step with dividend in acc_lo.
    assign w_add    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
    assign w_rsh    = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff   = w_rsh - {1'b0, r_b};
    assign w_hi_nx  = r_is_div ? (w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_add[WIDTH:1];
    assign w_lo_nx  = r_is_div ? {r_acc_lo[WIDTH-2:0], ~w_diff[WIDTH]} : {w_add[0], r_acc_lo[WIDTH-1:1]};
    assign w_prod   = r_neg_q ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};
    assign w_q      = r_neg_q ? -w_lo_nx : w_lo_nx;
    assign w_rem    = r_neg_r ? -w_hi_nx : w_hi_nx;
    assign w_wb_hi  = r_is_div ? (r_dz ? r_rs : w_rem) : w_prod[2*WIDTH-1:WIDTH];
    assign w_wb_lo  = r_is_div ? (r_dz ? '1 : w_q) : w_prod[WIDTH-1:0];
    assign mf_result = (ex_valid & w_mfhi) ? r_hi : (ex_valid & w_mflo) ? r_lo : '0;
    assign hi = r_hi;
    assign lo = r_lo;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_b      <= '0;
            r_rs     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (ex_valid & w_mthi) r_hi <= rs_data;
            if (ex_valid & w_mtlo) r_lo <= rs_data;
            if (w_start) begin
                r_state  <= S_RUN;
                r_cnt    <= '0;
                r_acc_hi <= '0;
                r_acc_lo <= w_a_mag;
                r_b      <= w_b_mag;
                r_rs     <= rs_data;
                r_is_div <= w_div | w_divu;
                r_neg_q  <= w_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                r_neg_r  <= w_signed & rs_data[WIDTH-1];
                r_dz     <= rt_data == '0;
            end
        end else begin
            r_acc_hi <= w_hi_nx;
            r_acc_lo <= w_lo_nx;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_hi    <= w_wb_hi;
                r_lo    <= w_wb_lo;
                r_state <= S_IDLE;
            end
        end
    end
endmodule
